// File: rtl/ceres_param.sv
// ---------------------------------------------------------------------------
// ceres_param
// Shared constants, types and helpers for the ceres UART transmit path.
//   CPU_CLK            default system clock frequency in Hz
//   UART_FRAME_BITS    start + 8 data + stop (parity is added on top)
//   UART_DATA_BITS     payload bits per frame
//   uart_tx_state_e    transmitter FSM states
//   uart_clks_per_bit  integer-truncated clocks per serial bit
// ---------------------------------------------------------------------------
package ceres_param;

    localparam int unsigned CPU_CLK         = 100_000_000;
    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_DATA_BITS  = UART_FRAME_BITS - 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    function automatic int unsigned uart_clks_per_bit(
        input int unsigned clk_freq_hz,
        input int unsigned baud_rate
    );
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_sync_fifo
// Single-clock FIFO with show-ahead read: pop_data_o always presents the
// head entry so the consumer can take it in the same cycle it pops.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   push_i, push_data_i  write request (ignored while full)
//   pop_i                remove head entry (ignored while empty)
//   pop_data_o           current head entry
//   count_o              occupancy, one bit wider than the pointers
//   empty_o, full_o      occupancy flags
// ---------------------------------------------------------------------------
module uart_tx_sync_fifo #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8-bit UART transmitter. Bytes enter a FIFO through a valid/ready
// port and are sent LSB-first as start / 8 data / optional even parity / stop.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   tx_en_i                 permits starting new frames
//   wr_valid_i, wr_data_i   byte write request
//   wr_ready_o              FIFO can accept a byte (not full)
//   tx_o                    registered serial line, idle high
//   busy_o                  FSM not idle
//   tx_done_o               one-cycle pulse at the end of each stop bit
//   fifo_count_o            FIFO occupancy
//   fifo_empty_o            occupancy == 0
//   fifo_full_o             occupancy == FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import ceres_param::*;
#(
    parameter int unsigned  CLK_FREQ_HZ = CPU_CLK,
    parameter int unsigned  BAUD_RATE   = 115200,
    parameter int unsigned  FIFO_DEPTH  = 16,
    parameter bit           PARITY_EN   = 1'b0,
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_en_i,
    input  logic             wr_valid_i,
    input  logic [7:0]       wr_data_i,
    output logic             wr_ready_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             tx_done_o,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic             fifo_empty_o,
    output logic             fifo_full_o
);

    localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_tx_state_e    state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic              fifo_pop;
    logic [7:0]        fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic              baud_last;
    logic              start_ok;

    uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (wr_valid_i),
        .push_data_i (wr_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign wr_ready_o   = !fifo_full;
    assign fifo_count_o = fifo_count;
    assign fifo_empty_o = fifo_empty;
    assign fifo_full_o  = fifo_full;
    assign busy_o       = (state_q != IDLE);
    assign tx_o         = tx_q;
    assign tx_done_o    = done_q;

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign start_ok  = tx_en_i && !fifo_empty;

    // Line level and done pulse are computed from the current state and
    // registered, so tx_o trails the state register by exactly one cycle.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = 1'b1;
        done_d   = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    parity_d = ^fifo_rd_data;
                    baud_d   = '0;
                    state_d  = START;
                end
            end

            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            PARITY: begin
                tx_d = parity_q;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    done_d = 1'b1;
                    baud_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (start_ok) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        parity_d = ^fifo_rd_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo at 10 clocks per bit. One instance runs
// without parity, a second with parity enabled. Edge N is the clock edge on
// which the first byte of a scenario is pushed; k counts edges after N.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tx_en, wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready, tx, busy, tx_done, empty, full;
    logic [4:0] count;

    logic       tx_en_p, wr_valid_p;
    logic [7:0] wr_data_p;
    logic       wr_ready_p, tx_p, busy_p, tx_done_p, empty_p, full_p;
    logic [4:0] count_p;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (100),
        .BAUD_RATE   (10),
        .FIFO_DEPTH  (16),
        .PARITY_EN   (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_en_i      (tx_en),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .tx_done_o    (tx_done),
        .fifo_count_o (count),
        .fifo_empty_o (empty),
        .fifo_full_o  (full)
    );

    uart_tx_fifo #(
        .CLK_FREQ_HZ (100),
        .BAUD_RATE   (10),
        .FIFO_DEPTH  (16),
        .PARITY_EN   (1'b1)
    ) dut_p (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_en_i      (tx_en_p),
        .wr_valid_i   (wr_valid_p),
        .wr_data_i    (wr_data_p),
        .wr_ready_o   (wr_ready_p),
        .tx_o         (tx_p),
        .busy_o       (busy_p),
        .tx_done_o    (tx_done_p),
        .fifo_count_o (count_p),
        .fifo_empty_o (empty_p),
        .fifo_full_o  (full_p)
    );

    // Expected line level k edges after the push edge of a lone frame.
    function automatic logic exp_tx(input logic [7:0] b, input int k, input bit par);
        int p;
        if (k < 2) return 1'b1;
        p = (k - 2) / CPB;
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (par && p == 9) return ^b;
        return 1'b1;
    endfunction

    task test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", wr_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (tx_p !== 1'b1) begin errors++; $display("FAIL reset_tx_p got %b want 1", tx_p); end
        checks++; if (count_p !== 5'd0) begin errors++; $display("FAIL reset_count_p got %0d want 0", count_p); end
        checks++; if (wr_ready_p !== 1'b1 || full_p !== 1'b0) begin
            errors++; $display("FAIL reset_flags_p got ready=%b full=%b want 1 0", wr_ready_p, full_p);
        end
        rst = 1'b0;
        $display("reset: tx=%b busy=%b count=%0d ready=%b", tx, busy, count, wr_ready);
    endtask

    task test_single();
        int nerr;
        nerr = errors;
        @(posedge clk); #1;
        wr_data = 8'hA5; wr_valid = 1'b1; tx_en = 1'b1;
        @(posedge clk); #1;               // edge N
        wr_valid = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_after_push got %0d want 1", count); end
        for (int k = 1; k <= 115; k++) begin
            @(posedge clk); #1;
            checks++; if (tx !== exp_tx(8'hA5, k, 1'b0)) begin
                errors++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_tx(8'hA5, k, 1'b0));
            end
            checks++; if (tx_done !== (k == 101)) begin
                errors++; $display("FAIL single_done k=%0d got %b want %b", k, tx_done, (k == 101));
            end
            checks++; if (busy !== (k < 101)) begin
                errors++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k < 101));
            end
            if (k == 1) begin
                checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop got %0d want 0", count); end
            end
        end
        $display("single 0xA5: new errors %0d", errors - nerr);
    endtask

    task test_back_to_back();
        int  nerr;
        int  pulses;
        logic want;
        nerr = errors; pulses = 0;
        tx_en = 1'b1;
        wr_data = 8'h00; wr_valid = 1'b1;
        @(posedge clk); #1;               // edge N
        wr_data = 8'hFF;
        @(posedge clk); #1;               // edge N+1
        wr_valid = 1'b0;
        for (int k = 2; k <= 215; k++) begin
            @(posedge clk); #1;
            want = (k < 102) ? exp_tx(8'h00, k, 1'b0) : exp_tx(8'hFF, k - 100, 1'b0);
            checks++; if (tx !== want) begin
                errors++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx, want);
            end
            checks++; if (tx_done !== (k == 101 || k == 201)) begin
                errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, tx_done, (k == 101 || k == 201));
            end
            if (tx_done === 1'b1) pulses++;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        $display("back_to_back 0x00,0xFF: done pulses %0d, new errors %0d", pulses, errors - nerr);
    endtask

    task test_full();
        int   nerr;
        int   idx;
        int   pulses;
        logic want;
        nerr = errors; pulses = 0;
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(16 + i); wr_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (count !== 5'((i < 16) ? i + 1 : 16)) begin
                errors++; $display("FAIL full_count i=%0d got %0d want %0d", i, count, (i < 16) ? i + 1 : 16);
            end
            checks++; if (full !== (i >= 15) || wr_ready !== (i < 15)) begin
                errors++; $display("FAIL full_flags i=%0d got full=%b ready=%b want %b %b", i, full, wr_ready, (i >= 15), (i < 15));
            end
        end
        wr_valid = 1'b0;
        tx_en = 1'b1;                     // current edge acts as k=0
        for (int k = 1; k <= 1615; k++) begin
            @(posedge clk); #1;
            idx = (k < 2) ? 0 : (k - 2) / 100;
            if (idx > 15) idx = 15;
            want = exp_tx(8'(16 + idx), k - 100 * idx, 1'b0);
            checks++; if (tx !== want) begin
                errors++; $display("FAIL full_tx k=%0d byte=%0h got %b want %b", k, 16 + idx, tx, want);
            end
            if (tx_done === 1'b1) pulses++;
        end
        checks++; if (pulses != 16) begin errors++; $display("FAIL full_frames got %0d want 16", pulses); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL full_drained got empty=%b busy=%b want 1 0", empty, busy);
        end
        $display("full/overflow 0x10-0x20: frames %0d, new errors %0d", pulses, errors - nerr);
    endtask

    task test_parity();
        logic [7:0] bytes [2];
        logic       want_par [2];
        int         nerr;
        bytes[0] = 8'h07; want_par[0] = 1'b1;
        bytes[1] = 8'h03; want_par[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            nerr = errors;
            @(posedge clk); #1;
            wr_data_p = bytes[t]; wr_valid_p = 1'b1; tx_en_p = 1'b1;
            @(posedge clk); #1;           // edge N
            wr_valid_p = 1'b0;
            for (int k = 1; k <= 120; k++) begin
                @(posedge clk); #1;
                checks++; if (tx_p !== exp_tx(bytes[t], k, 1'b1)) begin
                    errors++; $display("FAIL parity_tx byte=%0h k=%0d got %b want %b", bytes[t], k, tx_p, exp_tx(bytes[t], k, 1'b1));
                end
                checks++; if (tx_done_p !== (k == 111)) begin
                    errors++; $display("FAIL parity_done byte=%0h k=%0d got %b want %b", bytes[t], k, tx_done_p, (k == 111));
                end
                if (k == 97) begin
                    checks++; if (tx_p !== want_par[t]) begin
                        errors++; $display("FAIL parity_bit byte=%0h got %b want %b", bytes[t], tx_p, want_par[t]);
                    end
                end
            end
            checks++; if (busy_p !== 1'b0 || empty_p !== 1'b1) begin
                errors++; $display("FAIL parity_idle got busy=%b empty=%b want 0 1", busy_p, empty_p);
            end
            $display("parity byte 0x%0h: parity bit %b, new errors %0d", bytes[t], want_par[t], errors - nerr);
        end
    endtask

    task test_tx_en_mid();
        int   nerr;
        logic want;
        nerr = errors;
        tx_en = 1'b1;
        wr_data = 8'h3C; wr_valid = 1'b1;
        @(posedge clk); #1;               // edge N
        wr_data = 8'h5A;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        for (int k = 2; k <= 260; k++) begin
            @(posedge clk); #1;
            if (k == 40) tx_en = 1'b0;
            want = exp_tx(8'h3C, k, 1'b0);
            checks++; if (tx !== want) begin
                errors++; $display("FAIL txen_tx k=%0d got %b want %b", k, tx, want);
            end
            checks++; if (tx_done !== (k == 101)) begin
                errors++; $display("FAIL txen_done k=%0d got %b want %b", k, tx_done, (k == 101));
            end
        end
        checks++; if (count !== 5'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL txen_held got count=%0d busy=%b want 1 0", count, busy);
        end
        tx_en = 1'b1;                     // current edge acts as k=0
        for (int k = 1; k <= 115; k++) begin
            @(posedge clk); #1;
            checks++; if (tx !== exp_tx(8'h5A, k, 1'b0)) begin
                errors++; $display("FAIL txen_resume_tx k=%0d got %b want %b", k, tx, exp_tx(8'h5A, k, 1'b0));
            end
            checks++; if (tx_done !== (k == 101)) begin
                errors++; $display("FAIL txen_resume_done k=%0d got %b want %b", k, tx_done, (k == 101));
            end
        end
        $display("tx_en mid-frame 0x3C then 0x5A: new errors %0d", errors - nerr);
    endtask

    task test_reset_mid();
        int nerr;
        nerr = errors;
        tx_en = 1'b1;
        wr_data = 8'h96; wr_valid = 1'b1;
        @(posedge clk); #1;               // edge N
        wr_data = 8'h69;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (49) @(posedge clk);       // now at edge N+50
        #1;
        checks++; if (tx !== 1'b0 || count !== 5'd1) begin
            errors++; $display("FAIL rstmid_before got tx=%b count=%0d want 0 1", tx, count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL rstmid_fifo got count=%0d empty=%b want 0 1", count, empty);
        end
        checks++; if (busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got busy=%b done=%b want 0 0", busy, tx_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            checks++; if (tx !== 1'b1 || tx_done !== 1'b0) begin
                errors++; $display("FAIL rstmid_after k=%0d got tx=%b done=%b want 1 0", k, tx, tx_done);
            end
        end
        $display("reset mid-frame 0x96: new errors %0d", errors - nerr);
    endtask

    initial begin
        rst        = 1'b1;
        tx_en      = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        tx_en_p    = 1'b0;
        wr_valid_p = 1'b0;
        wr_data_p  = 8'h00;

        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_parity();
        test_tx_en_mid();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8-bit UART transmitter: the transmit-side counterpart to the SoC's UART/programming receivers.
- Bytes are pushed through a valid/ready write port into an internal FIFO, then serialised LSB-first as start / 8 data / optional parity / stop.
- Used inside the ceres peripheral set as a UART TX engine.
- Also used on the host/bench side to drive a programming RX line (prog_rx_i) at the system baud rate.

Parameters:
- CLK_FREQ_HZ, CPU_CLK: input clock frequency in Hz.
- BAUD_RATE, 115200: line rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer-truncated. Elaboration error if CLKS_PER_BIT < 2.
- FIFO_DEPTH, 16: byte entries. Must be a power of two, ≥ 2.
- PARITY_EN, 0: 1 inserts an even-parity bit between data and stop.

Ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  reset: one clock; reset is synchronous and active-high.
- tx_en_i  input  1  permits starting new frames.
- wr_valid_i  input  1  write request.
- wr_data_i  input  8  byte to transmit.
- wr_ready_o  output  1  FIFO can accept; equals !fifo_full_o.
- tx_o  output  1  serial line, idle high, registered.
- busy_o  output  1  FSM not in IDLE.
- tx_done_o  output  1  one-cycle pulse at end of each stop bit.
- fifo_count_o  output  $clog2(FIFO_DEPTH+1)  occupancy.
- fifo_empty_o  output  1  occupancy == 0.
- fifo_full_o  output  1  occupancy == FIFO_DEPTH.

Behaviour:
- Reset values (rst_i high at a rising edge): tx_o=1, busy_o=0, tx_done_o=0, fifo_count_o=0, fifo_empty_o=1, fifo_full_o=0, wr_ready_o=1. FSM goes to IDLE, baud and bit counters clear, FIFO pointers clear.
- Reset mid-frame aborts the frame. tx_o is 1 from the next cycle and all buffered bytes are discarded.
- Push: occurs on a clk_i edge where wr_valid_i && wr_ready_o. A write while full is ignored; there is no overwrite and no bypass.
- Pop: performed by the FSM only, on the IDLE→START or STOP→START transition.
- Simultaneous push and pop leaves the count unchanged. This is legal at full: the push is accepted only if ready was high, so full with a pop accepts nothing.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_o=1. If tx_en_i && !fifo_empty_o: pop the head into the shift register, clear the baud counter, go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx_o=shift[0] for CLKS_PER_BIT cycles per bit, shifting right each bit. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx_o = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. On the final cycle assert tx_done_o. Then:
  - if tx_en_i && !fifo_empty_o, go directly to START (pop; no idle gap);
  - otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO, with tx_en_i high and FSM idle, drives tx_o low from edge N+2. The frame lasts (10+PARITY_EN)·CLKS_PER_BIT cycles.
- tx_en_i deasserted mid-frame: the current frame completes; no new frame starts until it is reasserted. The FIFO still accepts writes.
- tx_o is driven from a flop; it has no combinational path from inputs.
- All counters wrap modulo their width. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count uses one extra bit.

Decomposition:
- ceres_param holds:
  - uart_tx_state_e (IDLE, START, DATA, PARITY, STOP);
  - the UART_FRAME_BITS constant (10);
  - a function computing CLKS_PER_BIT from CLK_FREQ_HZ and BAUD_RATE.
- One sub-module, uart_tx_sync_fifo: a parameterised synchronous FIFO (width 8, depth FIFO_DEPTH) with push/pop/count/empty/full and the same synchronous active-high reset.
- The FSM, baud counter and shifter live in uart_tx_fifo.

Test Plan:
- All scenarios use CLK_FREQ_HZ=100, BAUD_RATE=10 (CLKS_PER_BIT=10).
- Reset: hold rst_i 3 cycles → tx_o=1, busy_o=0, fifo_count_o=0, wr_ready_o=1.
- Single byte 0xA5, PARITY_EN=0, tx_en_i=1:
  - push at edge N → tx_o=0 from N+2, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop high;
  - tx_done_o pulses once at N+101;
  - busy_o returns to 0.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles → second start bit begins immediately after the first stop bit (no extra idle cycle); two tx_done_o pulses 100 cycles apart.
- Full/overflow, tx_en_i=0, FIFO_DEPTH=16: push 17 bytes 0x10–0x20 → fifo_full_o=1 and wr_ready_o=0 after 16; 0x20 dropped. Then tx_en_i=1 → exactly bytes 0x10–0x1F are transmitted in order.
- PARITY_EN=1, byte 0x07 → parity bit 1, frame 110 cycles. Byte 0x03 → parity bit 0.
- Mid-frame controls:
  - tx_en_i dropped during DATA of byte 0x3C → frame completes; the queued next byte is held until tx_en_i=1;
  - rst_i asserted during DATA → tx_o=1 next cycle, fifo_count_o=0, no tx_done_o.
